clock_mod_counter: RTL
======================

# clock_mod_counter

Parametrised, fully synchronous modulo counter that replaces the ripple-clocked per-field counters of the digital clock (seconds, minutes, hours). It counts in BCD or binary, counts up or down, and supports a configurable base value for 1-based fields such as 12-hour hours. It also provides a checked preset load and a registered carry/borrow output. Stages are cascaded by wiring each stage's `cout` to the next stage's `cin`, all on one clock.

## Interface
- `MODULUS`, default 60: number of distinct states; legal range 2..99 in BCD mode.
- `BASE`, default 0: lowest count value; the counter spans BASE..BASE+MODULUS-1.
- `WIDTH`, default 8: width of `value` and `pre_val`; must be a multiple of 4 in BCD mode.
- `clk` input, 1 bit: system clock, rising edge.
- `_CR` input, 1 bit: reset, asynchronous, active-low.
- `cin` input, 1 bit: count enable, a one-cycle pulse from the lower stage or tick source.
- `dir` input, 1 bit: 0 = count up, 1 = count down.
- `PE` input, 1 bit: synchronous preset load.
- `pre_val` input, WIDTH bits: preset value.
- `value` output, WIDTH bits: current count, registered.
- `cout` output, 1 bit: carry (up) or borrow (down) pulse, registered.
- `load_err` output, 1 bit: one-cycle pulse when a rejected preset was applied.

## Operation
- Priority within each cycle: `_CR` over `PE` over `cin`. When none is active, the counter holds.
- Reset (`_CR` low): `value` = BASE in the active encoding, `cout` = 0, `load_err` = 0. Takes effect immediately and holds while `_CR` is low.
- Load (`PE` high at the edge):
  - Valid preset: `pre_val` within BASE..BASE+MODULUS-1 and, in BCD mode, every nibble ≤ 9. `value` ← `pre_val`.
  - Invalid preset: `value` ← BASE and `load_err` = 1 for one cycle.
  - In both cases `cout` = 0 and `cin` is ignored that cycle.
- Count up (`cin`=1, `dir`=0):
  - If `value` = BASE+MODULUS-1: `value` ← BASE and `cout` = 1.
  - Otherwise: `value` ← `value`+1 and `cout` = 0.
- Count down (`cin`=1, `dir`=1):
  - If `value` = BASE: `value` ← BASE+MODULUS-1 and `cout` = 1.
  - Otherwise: `value` ← `value`-1 and `cout` = 0.
- BCD arithmetic:
  - Increment: low nibble 9 → 0 with a carry into the high nibble.
  - Decrement: low nibble 0 → 9 with a borrow from the high nibble.
  - The modulus comparison is made on the BCD-encoded constant.
- `cout` and `load_err` are high for exactly one cycle per event and are 0 in every other cycle.
- `dir` is sampled only in cycles where `cin`=1. Changing `dir` between pulses has no other effect.
- The counter never enters an out-of-range state. It has no internal FSM beyond the count register and the two pulse flags.

## Timing
- Count latency: 1 cycle. `value` and `cout` both update on the edge that samples `cin`=1.
- Cascade latency: stage N+1 advances one cycle after stage N wraps. The displayed value is therefore transiently inconsistent for one cycle per stage. This is accepted and is invisible at display refresh rates.
- Load latency: 1 cycle.
- Reset mid-count discards any pending wrap. `cout` is forced to 0 asynchronously.
- Release of `_CR` is expected to be synchronised upstream. The first count is accepted on the first edge after release.
- `cin` held high for K cycles advances the count K times. Callers must supply pulses, not levels.

## Configuration
- `CLOCK_CNT_BCD_EN` defined: `value` and `pre_val` are packed BCD, one nibble per decimal digit, and the BCD-validity check applies to loads.
- Not defined: plain binary encoding, no nibble check, and MODULUS is limited only by WIDTH.
- Port list and timing are identical in both builds.

## Structure
- Package `clock_cnt_pkg` holds:
  - the encoding enum (BIN, BCD);
  - the `to_bcd` constant function, used to convert BASE and BASE+MODULUS-1 at elaboration time;
  - the shared limits `SEC_MODULUS`=60, `MIN_MODULUS`=60, `HOUR24_MODULUS`=24, `HOUR12_MODULUS`=12.
- Sub-module `bcd_step`: one-nibble increment/decrement with carry/borrow in and out. It is instantiated WIDTH/4 times in BCD builds and unused in binary builds.
- Elaboration-time assertions check:
  - MODULUS ≥ 2;
  - BASE+MODULUS-1 fits in WIDTH;
  - in BCD builds, WIDTH is a multiple of 4.

## Test plan
- Reset mid-count: count to 0x37, pull `_CR` low between edges → `value`=0x00 and `cout`=0 immediately, and they stay so while `_CR` is low.
- Up wrap, MODULUS=60, BCD: load 0x58, apply 2 `cin` pulses → `value` 0x59 then 0x00, with `cout`=1 only on the 0x00 cycle.
- Down wrap: `value`=0x00, `dir`=1, one `cin` pulse → `value`=0x59 and `cout`=1 for one cycle. Next pulse → 0x58 with `cout`=0.
- Load check, BCD: `PE` with 0x45 → `value`=0x45 and `load_err`=0. `PE` with 0x75, and separately with 0x3A → `value`=0x00 and `load_err` pulses once for each.
- Simultaneous `PE`+`cin` at `value`=0x59 with `pre_val`=0x10 → `value`=0x10 and `cout`=0.
- Hour field, BASE=1, MODULUS=12: `value`=0x12, one `cin` → `value`=0x01 and `cout`=1. Reset → `value`=0x01.

Source files
------------

// File: rtl/clock_mod_counter_pkg.sv
// clock_cnt_pkg: encodings, field moduli and BCD conversion shared by the clock counters.
package clock_cnt_pkg;
   typedef enum logic {BIN, BCD} enc_e;
   localparam int SEC_MODULUS = 60;
   localparam int MIN_MODULUS = 60;
   localparam int HOUR24_MODULUS = 24;
   localparam int HOUR12_MODULUS = 12;
   function automatic int to_bcd(input int v);
      int r;
      int x;
      r = 0;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r = r | ((x % 10) << (4 * i));
         x = x / 10;
      end
      return r;
   endfunction
endpackage

// File: rtl/clock_mod_counter_bcd_step.sv
// bcd_step: one BCD digit incremented or decremented when ci is set, with carry/borrow out.
module bcd_step (
   input  logic [3:0] d,
   input  logic       dir,
   input  logic       ci,
   output logic [3:0] q,
   output logic       co
);
   logic at_edge;
   always_comb begin
      at_edge = dir ? (d == 4'd0) : (d == 4'd9);
      co = ci && at_edge;
      q = !ci ? d : at_edge ? (dir ? 4'd9 : 4'd0) : dir ? d - 4'd1 : d + 4'd1;
   end
endmodule

// File: rtl/clock_mod_counter.sv
// clock_mod_counter: cascadable modulo counter stage, up/down, preset load with range check.
// Packed BCD when CLOCK_CNT_BCD_EN is defined, plain binary otherwise.
module clock_mod_counter
   import clock_cnt_pkg::*;
#(
   parameter int MODULUS = SEC_MODULUS,
   parameter int BASE = 0,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             _CR,
   input  logic             cin,
   input  logic             dir,
   input  logic             PE,
   input  logic [WIDTH-1:0] pre_val,
   output logic [WIDTH-1:0] value,
   output logic             cout,
   output logic             load_err
);
`ifdef CLOCK_CNT_BCD_EN
   localparam enc_e ENC = BCD;
`else
   localparam enc_e ENC = BIN;
`endif
   localparam int LO = (ENC == BCD) ? to_bcd(BASE) : BASE;
   localparam int HI = (ENC == BCD) ? to_bcd(BASE + MODULUS - 1) : BASE + MODULUS - 1;
   localparam logic [WIDTH-1:0] LO_V = LO[WIDTH-1:0];
   localparam logic [WIDTH-1:0] HI_V = HI[WIDTH-1:0];
   if (MODULUS < 2) begin : g_chk_mod
      $error("clock_mod_counter: MODULUS must be at least 2");
   end
   if (WIDTH < 31 && HI >= (1 << WIDTH)) begin : g_chk_fit
      $error("clock_mod_counter: BASE+MODULUS-1 does not fit in WIDTH");
   end
   logic [WIDTH-1:0] value_q, value_d, step_v;
   logic             cout_q, cout_d, load_err_q, load_err_d;
   logic             in_range, pre_ok, wrap;
   assign in_range = (pre_val >= LO_V) && (pre_val <= HI_V);
`ifdef CLOCK_CNT_BCD_EN
   localparam int N = WIDTH / 4;
   if (WIDTH % 4 != 0) begin : g_chk_bcd
      $error("clock_mod_counter: WIDTH must be a multiple of 4 in BCD builds");
   end
   logic [N:0]   c;
   logic [N-1:0] nib_ok;
   logic         carry_unused;
   assign c[0] = 1'b1;
   assign carry_unused = c[N];
   for (genvar g = 0; g < N; g++) begin : g_nib
      bcd_step u_step (
         .d   (value_q[4*g +: 4]),
         .dir (dir),
         .ci  (c[g]),
         .q   (step_v[4*g +: 4]),
         .co  (c[g+1])
      );
      assign nib_ok[g] = pre_val[4*g +: 4] <= 4'd9;
   end
   assign pre_ok = in_range && (&nib_ok);
`else
   localparam logic [WIDTH-1:0] ONE = 1;
   assign step_v = dir ? value_q - ONE : value_q + ONE;
   assign pre_ok = in_range;
`endif
   always_comb begin
      wrap = dir ? (value_q == LO_V) : (value_q == HI_V);
      value_d = PE ? (pre_ok ? pre_val : LO_V) : cin ? (wrap ? (dir ? HI_V : LO_V) : step_v) : value_q;
      cout_d = !PE && cin && wrap;
      load_err_d = PE && !pre_ok;
   end
   always_ff @(posedge clk or negedge _CR) begin
      if (!_CR) begin
         value_q <= LO_V;
         cout_q <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         value_q <= value_d;
         cout_q <= cout_d;
         load_err_q <= load_err_d;
      end
   end
   assign value = value_q;
   assign cout = cout_q;
   assign load_err = load_err_q;
endmodule
